debouncer_multi: RTL and testbench

- N-channel switch debouncer with a shared sample-tick generator and one FSM per channel.
- Debounces both press and release, not press only. Stability time is set by tick period times tick count.
- Each channel gives a level output plus one-cycle rise and fall pulses.
- Sits between board-level buttons/switches and control logic. Replaces the single-channel, press-only debouncer.

---
 rtl/debounce_pkg.sv | 20 ++
 rtl/debounce_tick_gen.sv | 38 +++
 rtl/debouncer_multi.sv | 159 +++++++++++++++
 tb/tb_debouncer_multi.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared definitions for the multi-channel debouncer: channel FSM states,
// sample-tick period calculation and synchroniser depth.
package debounce_pkg;

   typedef enum logic [1:0] {
      ZERO  = 2'd0,
      WAIT1 = 2'd1,
      ONE   = 2'd2,
      WAIT0 = 2'd3
   } db_state_t;

   // Number of flops between the raw switch pin and the channel FSM
   localparam int SYNC_DEPTH = 2;

   // Sample-tick period in clk cycles (integer MHz times microseconds)
   function automatic int tick_cycles(input int clk_freq, input int sample_us);
      return (clk_freq / 1_000_000) * sample_us;
   endfunction

endpackage

// File: rtl/debounce_tick_gen.sv
// Free-running sample-tick generator shared by all debouncer channels.
// tick is high for one cycle every TICK_CYC cycles; the first tick is
// consumed on the TICK_CYC-th rising edge after reset release.
module debounce_tick_gen
   import debounce_pkg::*;
#(
   parameter int CLK_FREQ  = 100_000_000,
   parameter int SAMPLE_US = 5000
) (
   input  logic clk,
   input  logic reset_n,
   output logic tick
);

   localparam int TICK_CYC = tick_cycles(CLK_FREQ, SAMPLE_US);
   localparam int CNT_W    = (TICK_CYC < 2) ? 1 : $clog2(TICK_CYC);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_CYC - 1);

   if (TICK_CYC < 2) begin : g_bad_tick
      $error("debounce_tick_gen: sample period shorter than 2 clk cycles");
   end

   logic [CNT_W-1:0] r_cnt;

   // Period counter, wraps from TICK_CYC-1 back to 0
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign tick = (r_cnt == CNT_LAST);

endmodule

// File: rtl/debouncer_multi.sv
// N-channel press/release switch debouncer.
// Each channel: 2-flop synchroniser, 4-state FSM clocked by a shared sample
// tick, registered level output plus one-cycle rise/fall pulses.
// Optional long-press detection is built when DEBOUNCER_LONG_PRESS_EN is
// defined; otherwise long_press is tied to 0.
module debouncer_multi
   import debounce_pkg::*;
#(
   parameter int N_CH       = 4,
   parameter int CLK_FREQ   = 100_000_000,
   parameter int SAMPLE_US  = 5000,
   parameter int DB_TICKS   = 2,
   parameter int LONG_TICKS = 200
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic [N_CH-1:0] sw,
   output logic [N_CH-1:0] db,
   output logic [N_CH-1:0] rise,
   output logic [N_CH-1:0] fall,
   output logic [N_CH-1:0] long_press
);

   localparam int CNT_W = $clog2(DB_TICKS + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_TICKS - 1);

   if (N_CH < 1 || DB_TICKS < 1 || LONG_TICKS < 1) begin : g_bad_param
      $error("debouncer_multi: N_CH, DB_TICKS and LONG_TICKS must be >= 1");
   end

   logic [SYNC_DEPTH-1:0][N_CH-1:0] r_sync;
   logic [N_CH-1:0]                 w_s;
   logic                            w_tick;

   // Two-stage synchroniser for every raw switch input
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_DEPTH-2:0], sw};
      end
   end

   assign w_s = r_sync[SYNC_DEPTH-1];

   debounce_tick_gen #(
      .CLK_FREQ  (CLK_FREQ),
      .SAMPLE_US (SAMPLE_US)
   ) u_tick_gen (
      .clk     (clk),
      .reset_n (reset_n),
      .tick    (w_tick)
   );

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      db_state_t        r_state;
      logic [CNT_W-1:0] r_cnt;
      logic             r_db;
      logic             r_rise;
      logic             r_fall;
      logic             w_release_done;

      // Release has been stable long enough: this cycle leaves the held region
      assign w_release_done = (r_state == WAIT0) && !w_s[g] && w_tick &&
                              (r_cnt == CNT_LAST);

      // Channel FSM with registered level and edge pulses
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            r_state <= ZERO;
            r_cnt   <= '0;
            r_db    <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
         end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            case (r_state)
               ZERO: begin
                  if (w_s[g]) begin
                     r_state <= WAIT1;
                     r_cnt   <= '0;
                  end
               end
               WAIT1: begin
                  if (!w_s[g]) begin
                     r_state <= ZERO;
                  end else if (w_tick) begin
                     if (r_cnt == CNT_LAST) begin
                        r_state <= ONE;
                        r_db    <= 1'b1;
                        r_rise  <= 1'b1;
                     end else begin
                        r_cnt <= r_cnt + 1'b1;
                     end
                  end
               end
               ONE: begin
                  if (!w_s[g]) begin
                     r_state <= WAIT0;
                     r_cnt   <= '0;
                  end
               end
               WAIT0: begin
                  if (w_s[g]) begin
                     r_state <= ONE;
                  end else if (w_release_done) begin
                     r_state <= ZERO;
                     r_db    <= 1'b0;
                     r_fall  <= 1'b1;
                  end else if (w_tick) begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
               default: begin
                  r_state <= ZERO;
               end
            endcase
         end
      end

      assign db[g]   = r_db;
      assign rise[g] = r_rise;
      assign fall[g] = r_fall;

`ifdef DEBOUNCER_LONG_PRESS_EN
      localparam int HOLD_W = $clog2(LONG_TICKS + 1);
      localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_TICKS);

      logic [HOLD_W-1:0] r_hold;
      logic              r_long;

      // Hold-time counter: counts ticks while held, saturates, fires once
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            r_hold <= '0;
            r_long <= 1'b0;
         end else begin
            r_long <= 1'b0;
            if ((r_state == ONE || r_state == WAIT0) && !w_release_done) begin
               if (w_tick && (r_hold != HOLD_MAX)) begin
                  r_hold <= r_hold + 1'b1;
                  if (r_hold == HOLD_MAX - 1'b1) begin
                     r_long <= 1'b1;
                  end
               end
            end else begin
               r_hold <= '0;
            end
         end
      end

      assign long_press[g] = r_long;
`else
      assign long_press[g] = 1'b0;
`endif
   end

endmodule

// File: tb/tb_debouncer_multi.sv
// Self-checking bench for debouncer_multi (TICK_CYC=100, DB_TICKS=3,
// LONG_TICKS=5). Expected pulses are queued with an allowed cycle window
// when stimulus is applied and matched by a monitor as the DUT emits them.
`timescale 1ns/1ps
module tb_debouncer_multi;

   localparam int N_CH       = 4;
   localparam int CLK_FREQ   = 1_000_000;
   localparam int SAMPLE_US  = 100;
   localparam int DB_TICKS   = 3;
   localparam int LONG_TICKS = 5;

   // Press/release latency window from the cycle sw changes to the cycle the
   // pulse is seen: 2 sync + 1 FSM entry + first tick 1..100 + 2 more ticks.
   localparam int LAT_LO = 203;
   localparam int LAT_HI = 304;
   localparam int KIND_RISE = 0;
   localparam int KIND_FALL = 1;
   localparam int KIND_LONG = 2;

   logic            clk = 1'b0;
   logic            reset_n = 1'b0;
   logic [N_CH-1:0] sw = '0;
   logic [N_CH-1:0] db, rise, fall, long_press;

   int cyc = 0;
   int n_checks = 0;
   int n_fail = 0;

   typedef struct {
      int ch;
      int kind;
      int lo;
      int hi;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;
   logic mon_p;

   debouncer_multi #(
      .N_CH       (N_CH),
      .CLK_FREQ   (CLK_FREQ),
      .SAMPLE_US  (SAMPLE_US),
      .DB_TICKS   (DB_TICKS),
      .LONG_TICKS (LONG_TICKS)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .sw         (sw),
      .db         (db),
      .rise       (rise),
      .fall       (fall),
      .long_press (long_press)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Pulse monitor: every pulse must match the head of the expectation queue
   always @(negedge clk) begin
      for (int c = 0; c < N_CH; c++) begin
         if (rise[c] && fall[c]) begin
            n_checks++;
            n_fail++;
            $display("FAIL rise_and_fall ch%0d cycle %0d: both high, required exclusive", c, cyc);
         end
         for (int k = 0; k < 3; k++) begin
            mon_p = (k == 0) ? rise[c] : (k == 1) ? fall[c] : long_press[c];
            if (mon_p) begin
               n_checks++;
               if (q.size() == 0) begin
                  n_fail++;
                  $display("FAIL unexpected_pulse ch%0d kind %0d cycle %0d: got pulse, required none", c, k, cyc);
               end else begin
                  mon_e = q.pop_front();
                  if (mon_e.ch != c || mon_e.kind != k || cyc < mon_e.lo || cyc > mon_e.hi) begin
                     n_fail++;
                     $display("FAIL pulse_match cycle %0d: got ch%0d kind %0d, required ch%0d kind %0d in [%0d,%0d]",
                              cyc, c, k, mon_e.ch, mon_e.kind, mon_e.lo, mon_e.hi);
                  end
               end
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic expect_evt(input int ch, input int kind, input int lo, input int hi);
      exp_t e;
      e.ch = ch; e.kind = kind; e.lo = lo; e.hi = hi;
      q.push_back(e);
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      sw = '0;
      wait_cyc(3);
      n_checks++;
      if (db !== '0) begin n_fail++; $display("FAIL reset_db: got %b, required 0000", db); end
      n_checks++;
      if (rise !== '0 || fall !== '0) begin n_fail++; $display("FAIL reset_pulses: rise %b fall %b, required 0", rise, fall); end
      n_checks++;
      if (long_press !== '0) begin n_fail++; $display("FAIL reset_long: got %b, required 0000", long_press); end
      reset_n = 1'b1;
      wait_cyc(350);
      n_checks++;
      if (db !== '0) begin n_fail++; $display("FAIL idle_db: got %b, required 0000", db); end
   endtask

   task automatic test_clean_press();
      int k;
      bit others_bad;
      others_bad = 1'b0;
      k = cyc;
      sw[0] = 1'b1;
      expect_evt(0, KIND_RISE, k + LAT_LO, k + LAT_HI);
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (db[3:1] != 3'b000 || rise[3:1] != 3'b000) others_bad = 1'b1;
      end
      n_checks++;
      if (others_bad) begin n_fail++; $display("FAIL press_isolation: other channels active, required 0"); end
      n_checks++;
      if (db !== 4'b0001) begin n_fail++; $display("FAIL press_db: got %b, required 0001", db); end
      k = cyc;
      sw[0] = 1'b0;
      expect_evt(0, KIND_FALL, k + LAT_LO, k + LAT_HI);
      wait_cyc(350);
      n_checks++;
      if (db !== 4'b0000) begin n_fail++; $display("FAIL release_db: got %b, required 0000", db); end
      n_checks++;
      if (q.size() != 0) begin n_fail++; $display("FAIL press_pending: %0d pulses missing, required 0", q.size()); end
   endtask

   task automatic test_bounce();
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 17; i++) begin
         sw[1] = ~sw[1];
         for (int j = 0; j < 30; j++) begin
            @(negedge clk);
            if (db[1]) seen = 1'b1;
         end
      end
      sw[1] = 1'b0;
      for (int j = 0; j < 400; j++) begin
         @(negedge clk);
         if (db[1]) seen = 1'b1;
      end
      n_checks++;
      if (seen) begin n_fail++; $display("FAIL bounce_db: db[1] went 1, required stay 0"); end
      n_checks++;
      if (q.size() != 0) begin n_fail++; $display("FAIL bounce_pending: %0d entries, required 0", q.size()); end
   endtask

   task automatic test_release_bounce();
      int k;
      bit dropped;
      dropped = 1'b0;
      k = cyc;
      sw[2] = 1'b1;
      expect_evt(2, KIND_RISE, k + LAT_LO, k + LAT_HI);
      wait_cyc(350);
      n_checks++;
      if (db[2] !== 1'b1) begin n_fail++; $display("FAIL hold_db2: got %b, required 1", db[2]); end
      for (int b = 0; b < 6; b++) begin
         sw[2] = b[0];
         for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            if (!db[2]) dropped = 1'b1;
         end
      end
      k = cyc;
      sw[2] = 1'b0;
      expect_evt(2, KIND_FALL, k + LAT_LO, k + LAT_HI);
      for (int j = 0; j < LAT_LO - 1; j++) begin
         @(negedge clk);
         if (!db[2]) dropped = 1'b1;
      end
      n_checks++;
      if (dropped) begin n_fail++; $display("FAIL bounce_hold: db[2] dropped early, required 1"); end
      wait_cyc(200);
      n_checks++;
      if (db[2] !== 1'b0) begin n_fail++; $display("FAIL release_db2: got %b, required 0", db[2]); end
      n_checks++;
      if (q.size() != 0) begin n_fail++; $display("FAIL release_pending: %0d missing, required 0", q.size()); end
   endtask

   task automatic test_back_to_back();
      int k;
      k = cyc;
      sw = 4'b1111;
      for (int c = 0; c < N_CH; c++) expect_evt(c, KIND_RISE, k + LAT_LO, k + LAT_HI);
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (db != 4'b0000) break;
      end
      n_checks++;
      if (db !== 4'b1111 || rise !== 4'b1111) begin
         n_fail++; $display("FAIL simul_rise: db %b rise %b, required 1111 1111", db, rise);
      end
      wait_cyc(150);
      k = cyc;
      sw = 4'b0000;
      for (int c = 0; c < N_CH; c++) expect_evt(c, KIND_FALL, k + LAT_LO, k + LAT_HI);
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (db != 4'b1111) break;
      end
      n_checks++;
      if (db !== 4'b0000 || fall !== 4'b1111) begin
         n_fail++; $display("FAIL simul_fall: db %b fall %b, required 0000 1111", db, fall);
      end
      wait_cyc(20);
      n_checks++;
      if (q.size() != 0) begin n_fail++; $display("FAIL simul_pending: %0d missing, required 0", q.size()); end
   endtask

   task automatic test_reset_mid();
      int k;
      int r;
      k = cyc;
      sw[3] = 1'b1;
      expect_evt(3, KIND_RISE, k + LAT_LO, k + LAT_HI);
      wait_cyc(350);
      n_checks++;
      if (db !== 4'b1000) begin n_fail++; $display("FAIL pre_reset_db: got %b, required 1000", db); end
      sw[0] = 1'b1;
      wait_cyc(50);
      #2;
      reset_n = 1'b0;
      #1;
      n_checks++;
      if (db !== 4'b0000 || rise !== '0 || fall !== '0 || long_press !== '0) begin
         n_fail++; $display("FAIL async_reset: db %b rise %b fall %b long %b, required all 0", db, rise, fall, long_press);
      end
      wait_cyc(3);
      reset_n = 1'b1;
      r = cyc;
      // Tick counter restarts: third tick lands on the 300th edge after release
      expect_evt(0, KIND_RISE, r + 299, r + 301);
      expect_evt(3, KIND_RISE, r + 299, r + 301);
      wait_cyc(400);
      n_checks++;
      if (db !== 4'b1001) begin n_fail++; $display("FAIL post_reset_db: got %b, required 1001", db); end
      k = cyc;
      sw = 4'b0000;
      expect_evt(0, KIND_FALL, k + LAT_LO, k + LAT_HI);
      expect_evt(3, KIND_FALL, k + LAT_LO, k + LAT_HI);
      wait_cyc(350);
      n_checks++;
      if (db !== 4'b0000 || q.size() != 0) begin
         n_fail++; $display("FAIL post_reset_release: db %b pending %0d, required 0000 0", db, q.size());
      end
   endtask

   task automatic test_long_press();
      int k;
      int n_long;
      int n_long_exp;
      n_long = 0;
      k = cyc;
      sw[3] = 1'b1;
      expect_evt(3, KIND_RISE, k + LAT_LO, k + LAT_HI);
`ifdef DEBOUNCER_LONG_PRESS_EN
      n_long_exp = 1;
      expect_evt(3, KIND_LONG, k + LAT_LO + LONG_TICKS * 100, k + LAT_HI + LONG_TICKS * 100);
`else
      n_long_exp = 0;
`endif
      for (int i = 0; i < 1200; i++) begin
         @(negedge clk);
         if (long_press[3]) n_long++;
      end
      n_checks++;
      if (n_long != n_long_exp) begin
         n_fail++; $display("FAIL long_count: got %0d pulses, required %0d", n_long, n_long_exp);
      end
      k = cyc;
      sw[3] = 1'b0;
      expect_evt(3, KIND_FALL, k + LAT_LO, k + LAT_HI);
      wait_cyc(350);
      n_checks++;
      if (db !== 4'b0000 || q.size() != 0) begin
         n_fail++; $display("FAIL long_release: db %b pending %0d, required 0000 0", db, q.size());
      end
   endtask

   initial begin
      test_reset();
      test_clean_press();
      test_bounce();
      test_release_bounce();
      test_back_to_back();
      test_reset_mid();
      test_long_press();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
